// File: rtl/btn_debounce.sv
// Push-button debouncer: 2-flop sync, 4-state FSM, press strobe and counter.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
`timescale 1ps/1ps
module btn_debounce #(
    parameter int unsigned DB_CYCLES     = 8,
    parameter int unsigned REPEAT_DELAY  = 32,
    parameter int unsigned REPEAT_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       btn_level,
    output logic       btn_pulse,
    output logic [7:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
    localparam logic [15:0] RPT_LAST   = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_RELOAD = 16'(REPEAT_DELAY - REPEAT_PERIOD);
`endif

    // Elaboration-time range checks on the timing parameters
    if (DB_CYCLES < 2 || DB_CYCLES > 65535) begin : g_bad_db
        $error("DB_CYCLES out of range");
    end
    if (REPEAT_DELAY < 2 || REPEAT_DELAY > 65535) begin : g_bad_rd
        $error("REPEAT_DELAY out of range");
    end
    if (REPEAT_PERIOD < 2 || REPEAT_PERIOD > 65535) begin : g_bad_rp
        $error("REPEAT_PERIOD out of range");
    end

    logic        sync1;
    logic        btn_s;
    state_t      state;
    logic [15:0] cnt;

    // Two-flop synchronizer for the raw asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn;
            btn_s <= sync1;
        end
    end

    // Debounce FSM with registered level, strobe and press counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
            press_cnt <= '0;
        end else begin
            btn_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= 16'd1;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= HELD;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_pulse <= 1'b1;
                        press_cnt <= press_cnt + 8'd1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= 16'd1;
                    end else begin
`ifdef BTN_AUTOREPEAT_EN
                        if (cnt == RPT_LAST) begin
                            cnt       <= RPT_RELOAD;
                            btn_pulse <= 1'b1;
                            press_cnt <= press_cnt + 8'd1;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
`else
                        cnt <= '0;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state     <= IDLE;
                        cnt       <= '0;
                        btn_level <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed self-checking bench for btn_debounce (DB=8, delay 32, period 16).
// Auto-repeat expectations follow BTN_AUTOREPEAT_EN when it is defined.
`timescale 1ps/1ps
module tb_btn_debounce;

    logic       clk;
    logic       rst;
    logic       btn;
    logic       btn_level;
    logic       btn_pulse;
    logic [7:0] press_cnt;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int dbl = 0;
    logic prev_pulse = 1'b0;

    btn_debounce #(
        .DB_CYCLES(8),
        .REPEAT_DELAY(32),
        .REPEAT_PERIOD(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .press_cnt(press_cnt)
    );

    // Posedges at 100, 200, ... so inputs change on negedges
    initial begin
        clk = 1'b1;
        forever #50 clk = ~clk;
    end

    // Pulse census and back-to-back strobe detection
    always @(negedge clk) begin
        if (btn_pulse) begin
            pulses++;
            if (prev_pulse) dbl++;
        end
        prev_pulse = btn_pulse;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_level", 32'(btn_level), 0);
        check("rst_pulse", 32'(btn_pulse), 0);
        check("rst_cnt", 32'(press_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    int p0;
    int exp_rep;

    initial begin
        rst = 1'b1;
        btn = 1'b0;
        #20;
        check("por_level", 32'(btn_level), 0);
        check("por_pulse", 32'(btn_pulse), 0);
        check("por_cnt", 32'(press_cnt), 0);
        #130;
        rst = 1'b0;

        // Idle for 100 cycles
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check("idle_level", 32'(btn_level), 0);
            check("idle_pulse", 32'(btn_pulse), 0);
        end
        check("idle_cnt", 32'(press_cnt), 0);

        // Clean press: pulse in the cycle after E9
        btn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("lat_pulse_early", 32'(btn_pulse), 0);
            check("lat_level_early", 32'(btn_level), 0);
        end
        @(negedge clk);
        check("lat_pulse", 32'(btn_pulse), 1);
        check("lat_level", 32'(btn_level), 1);
        check("lat_cnt", 32'(press_cnt), 1);
        @(negedge clk);
        check("lat_pulse_off", 32'(btn_pulse), 0);
        check("lat_level_hold", 32'(btn_level), 1);
        repeat (24) @(negedge clk);
        check("hold_level", 32'(btn_level), 1);
        check("hold_cnt", 32'(press_cnt), 1);

        // Release: level drops after 10 edges, no pulse
        btn = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("rel_level_hold", 32'(btn_level), 1);
        end
        @(negedge clk);
        check("rel_level_drop", 32'(btn_level), 0);
        repeat (10) @(negedge clk);
        check("rel_cnt", 32'(press_cnt), 1);
        check("rel_pulses", 32'(pulses), 1);

        // Bounce every 5 cycles: never accepted
        do_reset();
        p0 = pulses;
        for (int c = 0; c < 60; c++) begin
            btn = ((c / 5) % 2) == 0;
            @(negedge clk);
            check("bnc_level", 32'(btn_level), 0);
            check("bnc_pulse", 32'(btn_pulse), 0);
        end
        btn = 1'b0;
        repeat (12) @(negedge clk);
        check("bnc_cnt", 32'(press_cnt), 0);
        check("bnc_pulses", 32'(pulses - p0), 0);

        // One-cycle dropout mid-qualification restarts the count
        btn = 1'b1;
        repeat (6) @(negedge clk);
        btn = 1'b0;
        @(negedge clk);
        btn = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("rst19_pulse_early", 32'(btn_pulse), 0);
            check("rst19_level_early", 32'(btn_level), 0);
        end
        @(negedge clk);
        check("rst19_pulse", 32'(btn_pulse), 1);
        check("rst19_cnt", 32'(press_cnt), 1);
        btn = 1'b0;
        repeat (15) @(negedge clk);

        // 256 clean presses wrap the counter
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            btn = 1'b1;
            repeat (20) @(negedge clk);
            btn = 1'b0;
            repeat (20) @(negedge clk);
            if (i == 254) check("wrap_255", 32'(press_cnt), 255);
        end
        check("wrap_0", 32'(press_cnt), 0);
        check("wrap_pulses", 32'(pulses - p0), 256);
        check("wrap_level", 32'(btn_level), 0);

        // Reset while held: async clear, full latency afterwards
        do_reset();
        btn = 1'b1;
        repeat (15) @(negedge clk);
        check("mid_level", 32'(btn_level), 1);
        check("mid_cnt", 32'(press_cnt), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_level", 32'(btn_level), 0);
        check("mid_rst_pulse", 32'(btn_pulse), 0);
        check("mid_rst_cnt", 32'(press_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("mid_pulse_early", 32'(btn_pulse), 0);
        end
        @(negedge clk);
        check("mid_pulse", 32'(btn_pulse), 1);
        check("mid_level_up", 32'(btn_level), 1);
        check("mid_cnt_up", 32'(press_cnt), 1);

        // Keep holding 100 cycles: repeats only with the macro
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
`ifdef BTN_AUTOREPEAT_EN
            exp_rep = (k >= 32 && ((k - 32) % 16) == 0) ? 1 : 0;
`else
            exp_rep = 0;
`endif
            check("rep_pulse", 32'(btn_pulse), 32'(exp_rep));
        end
`ifdef BTN_AUTOREPEAT_EN
        check("rep_cnt", 32'(press_cnt), 6);
`else
        check("rep_cnt", 32'(press_cnt), 1);
`endif
        check("rep_level", 32'(btn_level), 1);
        btn = 1'b0;
        repeat (15) @(negedge clk);
        check("end_level", 32'(btn_level), 0);
        check("no_double_pulse", 32'(dbl), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
